ex: RTL
=======

EX -- requirements
Module: ex

Interface
REQ-001 The block SHALL provide `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL provide `rst`, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL provide `aluop_ex`, input, 8 bits (`AluOpBus`): operation code from the ID/EX register.
REQ-004 The block SHALL provide `alusel_ex`, input, 3 bits (`AluSelBus`): result class (NOP, LOGIC, SHIFT, ARITH, MOVE).
REQ-005 The block SHALL provide `reg1_ex` and `reg2_ex`, inputs, 32 bits each (`RegBus`): operands.
REQ-006 The block SHALL provide `wr_addr_ex`, input, 5 bits, and `reg_we_ex`, input, 1 bit: destination register and write enable.
REQ-007 The block SHALL provide `flush_i`, input, 1 bit: synchronous cancel of an in-flight divide.
REQ-008 The block SHALL provide `wr_data_o`, output, 32 bits: GPR write data.
REQ-009 The block SHALL provide `wr_addr_o`, output, 5 bits, and `we_o`, output, 1 bit: GPR destination and write enable.
REQ-010 The block SHALL provide `stallreq_o`, output, 1 bit: request that the pipeline freeze ID/EX and everything upstream.
REQ-011 The block SHALL provide `hi_o` and `lo_o`, outputs, 32 bits each: the current HI/LO register contents.

Function
REQ-012 `wr_data_o`, `wr_addr_o`, `we_o` SHALL be combinational from the current inputs and HI/LO, with zero-cycle latency; `wr_addr_o`=`wr_addr_ex`, `we_o`=`reg_we_ex`.
REQ-013 LOGIC: OR, AND, XOR, NOR are bitwise on `reg1_ex`/`reg2_ex`.
REQ-014 SHIFT: SLL, SRL, SRA shift `reg2_ex` by `reg1_ex`[4:0]; SRA is sign-filling.
REQ-015 ARITH: ADDU and SUBU are 32-bit modulo with no overflow trap; SLT is a signed compare and SLTU an unsigned compare, giving 1 or 0.
REQ-016 MOVE: MFHI/MFLO output HI/LO; MTHI/MTLO write `reg1_ex` into HI/LO at the next edge when `stallreq_o`=0.
REQ-017 NOP or an unknown selection SHALL output `wr_data_o`=0.
REQ-018 DIV/DIVU SHALL run a 4-state FSM: IDLE, DIVZERO, ON, END.
REQ-019 IDLE with DIV/DIVU present SHALL go to DIVZERO if `reg2_ex`==0; otherwise it SHALL go to ON with the count at 0.
REQ-020 ON SHALL perform one radix-2 restoring step per cycle and go to END after 32 steps.
REQ-021 DIVZERO SHALL go to END after 1 cycle with quotient=remainder=0.
REQ-022 END SHALL write LO=quotient and HI=remainder at its edge, then return to IDLE.
REQ-023 DIV SHALL operate on magnitudes; the quotient is negated when the operand signs differ, and the remainder takes the sign of the dividend.
REQ-024 `stallreq_o` SHALL be 1 in IDLE-with-divide, DIVZERO and ON, and 0 in END and otherwise.
- Timing: nonzero divisor gives 33 stall cycles; zero divisor gives 2 stall cycles.
REQ-025 Operands SHALL be latched on leaving IDLE; input changes during ON are ignored.
REQ-026 When `flush_i`=1 in any state, the FSM SHALL go to IDLE at the next edge without a HI/LO write.
- Flush wins over END and over MTHI/MTLO in the same cycle.
REQ-027 MFHI/MFLO in the cycle immediately after an END or MTHI/MTLO SHALL see the new value, with no bypass needed.

Reset
REQ-028 Asserting `rst` (low) SHALL asynchronously clear HI, LO, the FSM (to IDLE), the count and the latched operands.
- Consequence: `stallreq_o`=0 during reset.
REQ-029 A reset in mid-divide SHALL abort the divide; no HI/LO write occurs after `rst` deasserts.

Structure
REQ-030 Opcodes (EXE_*_OP), result classes (EXE_RES_*), bus widths, and the `ZeroWord` and `RstEnable` constants SHALL live in the shared define file.
- The FSM state encodings SHALL also be added to that file.
REQ-031 The divider FSM, count and datapath SHALL be a sub-module named `div`, with start, signed, flush, operands, result and ready ports.
- HI/LO and the ALU SHALL stay in `ex`.

Verification
REQ-032 OR, reg1=0x0000FF00, reg2=0x00FF0000, addr=5, we=1 -> same cycle `wr_data_o`=0x00FFFF00, `wr_addr_o`=5, `we_o`=1.
REQ-033 SLT, reg1=0xFFFFFFFF, reg2=1 -> result 1; SLTU with the same operands -> result 0; SRA, reg1=4, reg2=0x80000000 -> result 0xF8000000.
REQ-034 DIV, reg1=0xFFFFFFF9 (-7), reg2=2 -> `stallreq_o` high for exactly 33 cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF; a following MFLO returns 0xFFFFFFFD.
REQ-035 DIVU, reg2=0 -> `stallreq_o` high for 2 cycles, then HI=LO=0.
REQ-036 MTHI 0x00001234, then MFHI the next cycle -> `wr_data_o`=0x00001234.
REQ-037 Mid-divide aborts from a prior HI=LO=0xAAAAAAAA:
- `flush_i` at step 10 -> `stallreq_o`=0 next cycle and HI/LO keep 0xAAAAAAAA.
- `rst` low at step 10 -> HI=LO=0 immediately and `stallreq_o`=0.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the EX stage: bus widths, opcodes, result classes,
// divider state encodings and a small magnitude helper.
package ex_pkg;

    localparam int RegWidth     = 32;
    localparam int AluOpWidth   = 8;
    localparam int AluSelWidth  = 3;
    localparam int RegAddrWidth = 5;

    localparam logic [31:0] ZeroWord  = 32'h0000_0000;
    localparam logic        RstEnable = 1'b0;

    // Operation codes carried in aluop_ex
    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
    localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
    localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
    localparam logic [7:0] EXE_MFHI_OP = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP = 8'b0001_0011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    // Result classes carried in alusel_ex
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;

    // Divider sequencing states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_ON   = 2'b10,
        DIV_END  = 2'b11
    } div_state_e;

    // Absolute value when the operand is treated as signed, unchanged otherwise
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic isSigned);
        return (isSigned && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider used by the EX stage for DIV/DIVU.
// Works on magnitudes and fixes the signs of quotient/remainder at the end.
module div
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic        flush_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        busy_o
);

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] divisor_q, divisor_d;
    logic        negQuot_q, negQuot_d;
    logic        negRem_q, negRem_d;

    logic [32:0] remShift;
    logic [32:0] diff;

    // Partial remainder shifted left with the next dividend bit, and trial subtraction
    assign remShift = {rem_q, quot_q[31]};
    assign diff     = remShift - {1'b0, divisor_q};

    // Register state, counter and datapath; reset aborts any divide in flight
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= 6'd0;
            quot_q    <= ZeroWord;
            rem_q     <= ZeroWord;
            divisor_q <= ZeroWord;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            negQuot_q <= negQuot_d;
            negRem_q  <= negRem_d;
        end
    end

    // Next-state and datapath step: latch operands leaving IDLE, one bit per ON cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        negQuot_d = negQuot_q;
        negRem_d  = negRem_q;
        case (state_q)
            DIV_IDLE: begin
                if (start_i) begin
                    negQuot_d = signed_i & (op1_i[31] ^ op2_i[31]);
                    negRem_d  = signed_i & op1_i[31];
                    divisor_d = magnitude(op2_i, signed_i);
                    cnt_d     = 6'd0;
                    rem_d     = ZeroWord;
                    if (op2_i == ZeroWord) begin
                        quot_d  = ZeroWord;
                        state_d = DIV_ZERO;
                    end else begin
                        quot_d  = magnitude(op1_i, signed_i);
                        state_d = DIV_ON;
                    end
                end
            end
            DIV_ZERO: begin
                quot_d    = ZeroWord;
                rem_d     = ZeroWord;
                negQuot_d = 1'b0;
                negRem_d  = 1'b0;
                state_d   = DIV_END;
            end
            DIV_ON: begin
                if (!diff[32]) begin
                    rem_d  = diff[31:0];
                    quot_d = {quot_q[30:0], 1'b1};
                end else begin
                    rem_d  = remShift[31:0];
                    quot_d = {quot_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = DIV_END;
                end
            end
            DIV_END: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
        if (flush_i) begin
            state_d = DIV_IDLE;
        end
    end

    assign result_o = {(negRem_q  ? (~rem_q  + 32'd1) : rem_q),
                       (negQuot_q ? (~quot_q + 32'd1) : quot_q)};
    assign ready_o  = (state_q == DIV_END) && !flush_i;
    assign busy_o   = (rst != RstEnable) &&
                      (((state_q == DIV_IDLE) && start_i) ||
                       (state_q == DIV_ZERO) || (state_q == DIV_ON));

endmodule

// File: rtl/ex.sv
// EX stage: combinational ALU, HI/LO registers and the multi-cycle divider.
module ex
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_ex,
    input  logic [2:0]  alusel_ex,
    input  logic [31:0] reg1_ex,
    input  logic [31:0] reg2_ex,
    input  logic [4:0]  wr_addr_ex,
    input  logic        reg_we_ex,
    input  logic        flush_i,
    output logic [31:0] wr_data_o,
    output logic [4:0]  wr_addr_o,
    output logic        we_o,
    output logic        stallreq_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] aluResult;
    logic        isDiv;
    logic        isSignedDiv;
    logic [63:0] divResult;
    logic        divReady;
    logic        divBusy;

    assign isDiv       = (aluop_ex == EXE_DIV_OP) || (aluop_ex == EXE_DIVU_OP);
    assign isSignedDiv = (aluop_ex == EXE_DIV_OP);

    div uDiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (isDiv),
        .signed_i (isSignedDiv),
        .flush_i  (flush_i),
        .op1_i    (reg1_ex),
        .op2_i    (reg2_ex),
        .result_o (divResult),
        .ready_o  (divReady),
        .busy_o   (divBusy)
    );

    // Single-cycle result selection by class, then by operation within the class
    always_comb begin
        aluResult = ZeroWord;
        case (alusel_ex)
            EXE_RES_LOGIC: begin
                case (aluop_ex)
                    EXE_OR_OP:  aluResult = reg1_ex | reg2_ex;
                    EXE_AND_OP: aluResult = reg1_ex & reg2_ex;
                    EXE_XOR_OP: aluResult = reg1_ex ^ reg2_ex;
                    EXE_NOR_OP: aluResult = ~(reg1_ex | reg2_ex);
                    default:    aluResult = ZeroWord;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (aluop_ex)
                    EXE_SLL_OP: aluResult = reg2_ex << reg1_ex[4:0];
                    EXE_SRL_OP: aluResult = reg2_ex >> reg1_ex[4:0];
                    EXE_SRA_OP: aluResult = $unsigned($signed(reg2_ex) >>> reg1_ex[4:0]);
                    default:    aluResult = ZeroWord;
                endcase
            end
            EXE_RES_ARITH: begin
                case (aluop_ex)
                    EXE_ADDU_OP: aluResult = reg1_ex + reg2_ex;
                    EXE_SUBU_OP: aluResult = reg1_ex - reg2_ex;
                    EXE_SLT_OP:  aluResult = {31'd0, ($signed(reg1_ex) < $signed(reg2_ex))};
                    EXE_SLTU_OP: aluResult = {31'd0, (reg1_ex < reg2_ex)};
                    default:     aluResult = ZeroWord;
                endcase
            end
            EXE_RES_MOVE: begin
                case (aluop_ex)
                    EXE_MFHI_OP: aluResult = hi_q;
                    EXE_MFLO_OP: aluResult = lo_q;
                    default:     aluResult = ZeroWord;
                endcase
            end
            default: aluResult = ZeroWord;
        endcase
    end

    // HI/LO update: divider completion first, then MTHI/MTLO; a flush cancels both
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (!flush_i) begin
            if (divReady) begin
                hi_d = divResult[63:32];
                lo_d = divResult[31:0];
            end else if (!divBusy) begin
                if (aluop_ex == EXE_MTHI_OP) begin
                    hi_d = reg1_ex;
                end
                if (aluop_ex == EXE_MTLO_OP) begin
                    lo_d = reg1_ex;
                end
            end
        end
    end

    // HI/LO storage, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            hi_q <= ZeroWord;
            lo_q <= ZeroWord;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign wr_data_o  = aluResult;
    assign wr_addr_o  = wr_addr_ex;
    assign we_o       = reg_we_ex;
    assign stallreq_o = divBusy;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule
